// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard: counter width, limits and
// the per-register counter step decision.
package hazard_scoreboard_pkg;

  localparam int SB_CNT_W = 2;
  localparam int SB_REG_W = 5;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  localparam sb_cnt_t SB_CNT_MAX = {SB_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // Simultaneous issue and retire cancel; saturation at either end holds the value.
  function automatic cnt_op_e cnt_op(input logic inc, input logic dec,
                                     input logic at_max, input logic at_zero);
    cnt_op_e op;
    if (inc && !dec && !at_max) begin
      op = CNT_INC;
    end else if (dec && !inc && !at_zero) begin
      op = CNT_DEC;
    end else begin
      op = CNT_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// One in-flight write counter for a single architectural register: saturating
// up/down count plus a combinational flag for a retire seen at zero.
module hazard_scoreboard_sb_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  cnt_op_e          op_s;

  // Next count from the shared step decision.
  always_comb begin
    op_s = cnt_op(inc, dec, cnt_q == CNT_MAX, cnt_q == '0);
    case (op_s)
      CNT_INC: cnt_d = cnt_q + CNT_ONE;
      CNT_DEC: cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  assign at_max    = (cnt_q == CNT_MAX);
  assign underflow = dec && (cnt_q == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight long-latency writes; stalls decode on unforwardable operands.
// Optional SCOREBOARD_WB_BYPASS_EN lets a last pending write retiring this cycle satisfy decode.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int CNT_W       = SB_CNT_W,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [SB_REG_W-1:0]    issue_rd,
  input  logic                   issue_long,
  input  logic [SB_REG_W-1:0]    rs_1,
  input  logic [SB_REG_W-1:0]    rs_2,
  input  logic                   rs_1_used,
  input  logic                   rs_2_used,
  input  logic                   wb_valid,
  input  logic [SB_REG_W-1:0]    wb_rd,
  output logic                   stall,
  output logic                   issue_fire,
  output logic                   busy,
  output logic                   underflow,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]       cnt_s [NUM_REGS];
  logic [NUM_REGS-1:0]    at_max_s;
  logic [NUM_REGS-1:0]    uf_s;
  logic [NUM_REGS-1:0]    nz_s;
  logic                   byp_1_s;
  logic                   byp_2_s;
  logic                   hz_1_s;
  logic                   hz_2_s;
  logic                   ovf_s;
  logic                   stall_s;
  logic                   busy_d;
  logic                   busy_q;
  logic                   underflow_d;
  logic                   underflow_q;
  logic [STALL_CNT_W-1:0] stall_count_d;
  logic [STALL_CNT_W-1:0] stall_count_q;

  // x0 is hardwired and never carries a pending write.
  assign cnt_s[0]    = '0;
  assign at_max_s[0] = 1'b0;
  assign uf_s[0]     = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    hazard_scoreboard_sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (issue_fire && issue_long && (issue_rd == SB_REG_W'(r))),
      .dec      (wb_valid && (wb_rd == SB_REG_W'(r))),
      .cnt      (cnt_s[r]),
      .at_max   (at_max_s[r]),
      .underflow(uf_s[r])
    );
  end

  // Operand hazards and WAW overflow from the registered counters.
  always_comb begin
`ifdef SCOREBOARD_WB_BYPASS_EN
    byp_1_s = wb_valid && (wb_rd == rs_1) && (cnt_s[rs_1] == CNT_ONE);
    byp_2_s = wb_valid && (wb_rd == rs_2) && (cnt_s[rs_2] == CNT_ONE);
`else
    byp_1_s = 1'b0;
    byp_2_s = 1'b0;
`endif
    hz_1_s  = rs_1_used && (rs_1 != 5'd0) && (cnt_s[rs_1] != '0) && !byp_1_s;
    hz_2_s  = rs_2_used && (rs_2 != 5'd0) && (cnt_s[rs_2] != '0) && !byp_2_s;
    ovf_s   = issue_valid && issue_long && (issue_rd != 5'd0) && at_max_s[issue_rd];
    stall_s = hz_1_s || hz_2_s || ovf_s;
  end

  assign stall      = stall_s;
  assign issue_fire = issue_valid && !stall_s;

  // Status and performance next-state.
  always_comb begin
    nz_s = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      nz_s[r] = (cnt_s[r] != '0);
    end
    busy_d      = |nz_s;
    underflow_d = underflow_q || (|uf_s);
    if (stall_s && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Status and performance registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q        <= 1'b0;
      underflow_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      busy_q        <= busy_d;
      underflow_q   <= underflow_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign busy        = busy_q;
  assign underflow   = underflow_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a per-register count model.
module tb_hazard_scoreboard;

  localparam int SC_W   = 6;
  localparam int SC_MAX = 63;
  localparam int C_MAX  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            issue_valid = 1'b0;
  logic [4:0]      issue_rd = 5'd0;
  logic            issue_long = 1'b0;
  logic [4:0]      rs_1 = 5'd0;
  logic [4:0]      rs_2 = 5'd0;
  logic            rs_1_used = 1'b0;
  logic            rs_2_used = 1'b0;
  logic            wb_valid = 1'b0;
  logic [4:0]      wb_rd = 5'd0;
  logic            stall;
  logic            issue_fire;
  logic            busy;
  logic            underflow;
  logic [SC_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  int m_cnt [32];
  int m_busy;
  int m_uf;
  int m_sc;

  hazard_scoreboard #(
    .NUM_REGS   (32),
    .CNT_W      (2),
    .STALL_CNT_W(SC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_long (issue_long),
    .rs_1       (rs_1),
    .rs_2       (rs_2),
    .rs_1_used  (rs_1_used),
    .rs_2_used  (rs_2_used),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .stall      (stall),
    .issue_fire (issue_fire),
    .busy       (busy),
    .underflow  (underflow),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit m_hz(input bit used, input int rs);
    bit h;
    h = used && (rs != 0) && (m_cnt[rs] != 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_valid && (int'(wb_rd) == rs) && (m_cnt[rs] == 1)) h = 1'b0;
`endif
    return h;
  endfunction

  // Model compare each cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (run) begin
      bit e_stall, e_fire, any_nz;
      if (!rst) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_busy = 0; m_uf = 0; m_sc = 0;
      end
      e_stall = m_hz(rs_1_used, int'(rs_1)) || m_hz(rs_2_used, int'(rs_2)) ||
                (issue_valid && issue_long && issue_rd != 5'd0 && m_cnt[issue_rd] == C_MAX);
      e_fire  = issue_valid && !e_stall;
      chk("stall", int'(stall), int'(e_stall));
      chk("issue_fire", int'(issue_fire), int'(e_fire));
      chk("busy", int'(busy), m_busy);
      chk("underflow", int'(underflow), m_uf);
      chk("stall_count", int'(stall_count), m_sc);
      if (rst) begin
        any_nz = 1'b0;
        foreach (m_cnt[i]) if (m_cnt[i] != 0) any_nz = 1'b1;
        m_busy = int'(any_nz);
        if (e_stall && m_sc < SC_MAX) m_sc++;
        for (int r = 1; r < 32; r++) begin
          bit inc, dec;
          inc = e_fire && issue_long && (int'(issue_rd) == r);
          dec = wb_valid && (int'(wb_rd) == r);
          if (dec && m_cnt[r] == 0) m_uf = 1;
          if (inc && !dec) m_cnt[r]++;
          else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
        end
      end
    end
  end

  task automatic apply(input bit r, input bit iv, input int ird, input bit il,
                       input int r1, input bit u1, input int r2, input bit u2,
                       input bit wv, input int wrd);
    @(posedge clk);
    #1;
    rst = r; issue_valid = iv; issue_rd = 5'(ird); issue_long = il;
    rs_1 = 5'(r1); rs_1_used = u1; rs_2 = 5'(r2); rs_2_used = u2;
    wb_valid = wv; wb_rd = 5'(wrd);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int s2;
    run = 1'b1;
    // Reset held while an issue is presented.
    apply(1'b0, 1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_fire", int'(issue_fire), 1);
    chk("rst_sc", int'(stall_count), 0);
    chk("rst_uf", int'(underflow), 0);
    chk("rst_busy", int'(busy), 0);
    idle();

    // Load x5 then dependent decode until writeback.
    apply(1'b1, 1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    chk("ld5_fire", int'(issue_fire), 1);
    repeat (3) begin
      apply(1'b1, 1'b0, 0, 1'b0, 5, 1'b1, 0, 1'b0, 1'b0, 0);
      chk("dep5_stall", int'(stall), 1);
    end
    apply(1'b1, 1'b0, 0, 1'b0, 5, 1'b1, 0, 1'b0, 1'b1, 5);
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("wb5_stall", int'(stall), 0);
    s2 = 3;
`else
    chk("wb5_stall", int'(stall), 1);
    s2 = 4;
`endif
    apply(1'b1, 1'b0, 0, 1'b0, 5, 1'b1, 0, 1'b0, 1'b0, 0);
    chk("post5_stall", int'(stall), 0);
    chk("post5_sc", int'(stall_count), s2);
    chk("post5_busy", int'(busy), 1);
    idle();
    chk("idle_busy", int'(busy), 0);

    // Three loads fill x7; a fourth is held off.
    repeat (3) begin
      apply(1'b1, 1'b1, 7, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0);
      chk("ld7_fire", int'(issue_fire), 1);
    end
    apply(1'b1, 1'b1, 7, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    chk("ld7_ovf_stall", int'(stall), 1);
    chk("ld7_ovf_fire", int'(issue_fire), 0);
    chk("model_cnt7", m_cnt[7], 3);
    repeat (3) apply(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 7);
    chk("ovf_sc", int'(stall_count), s2 + 1);
    idle();

    // Issue and retire of x9 in the same cycle.
    apply(1'b1, 1'b1, 9, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    apply(1'b1, 1'b1, 9, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 9);
    chk("same9_fire", int'(issue_fire), 1);
    apply(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0, 0);
    chk("same9_stall", int'(stall), 1);
    chk("model_cnt9", m_cnt[9], 1);
    apply(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 9);
    idle();

    // x0 is never tracked; retire at zero count is sticky underflow.
    apply(1'b1, 1'b1, 0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    apply(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0, 0);
    chk("x0_stall", int'(stall), 0);
    chk("x0_busy", int'(busy), 0);
    apply(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 3);
    chk("uf_pre", int'(underflow), 0);
    idle();
    chk("uf_set", int'(underflow), 1);
    chk("uf_busy", int'(busy), 0);

    // Long stall saturates the counter, then reset mid-stall.
    apply(1'b1, 1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    repeat (70) apply(1'b1, 1'b0, 0, 1'b0, 5, 1'b1, 0, 1'b0, 1'b0, 0);
    chk("sat_sc", int'(stall_count), SC_MAX);
    chk("sat_stall", int'(stall), 1);
    apply(1'b0, 1'b0, 0, 1'b0, 5, 1'b1, 0, 1'b0, 1'b0, 0);
    chk("midrst_stall", int'(stall), 0);
    chk("midrst_sc", int'(stall_count), 0);
    chk("midrst_uf", int'(underflow), 0);
    apply(1'b1, 1'b0, 0, 1'b0, 5, 1'b1, 0, 1'b0, 1'b0, 0);
    chk("postrst_stall", int'(stall), 0);
    chk("postrst_busy", int'(busy), 0);

    // Random traffic over a small register window to force collisions.
    for (int n = 0; n < 2000; n++) begin
      apply(($urandom_range(0, 149) != 0),
            ($urandom_range(0, 99) < 50), int'($urandom_range(0, 7)), ($urandom_range(0, 99) < 70),
            int'($urandom_range(0, 7)), ($urandom_range(0, 99) < 60),
            int'($urandom_range(0, 7)), ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 35), int'($urandom_range(0, 7)));
    end

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
